config_cmd_handler: RTL and testbench

CONFIG_CMD_HANDLER -- requirements
Module: config_cmd_handler

---
 rtl/config_cmd_handler.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_config_cmd_handler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_cmd_handler.sv
// Configuration command parser for the MCU UART link: loads/echoes the five
// configuration registers, answers config/version queries and requests soft reset.
module config_cmd_handler #(
  parameter int                    DATA_WIDTH         = 8,
  parameter logic [DATA_WIDTH-1:0] HEAD_DETECT_1      = 8'hC0,
  parameter logic [DATA_WIDTH-1:0] HEAD_DETECT_2      = 8'hC2,
  parameter logic [DATA_WIDTH-1:0] RET_CONFIG_DETECT  = 8'hC1,
  parameter logic [DATA_WIDTH-1:0] RET_VERSION_DETECT = 8'hC3,
  parameter logic [DATA_WIDTH-1:0] RESET_DETECT       = 8'hC4,
  parameter logic [DATA_WIDTH-1:0] VERSION_PACKET_1   = 8'hC3,
  parameter logic [DATA_WIDTH-1:0] VERSION_PACKET_2   = 8'h32,
  parameter logic [DATA_WIDTH-1:0] VERSION_PACKET_3   = 8'h27,
  parameter logic [DATA_WIDTH-1:0] VERSION_PACKET_4   = 8'h02,
  parameter int                    CMD_TIMEOUT        = 500000
) (
  input  logic                  internal_clk,
  input  logic                  rst_n,
  input  logic                  cmd_en,
  input  logic                  rx_flag,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  tx_ready,
  output logic                  tx_use,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic [DATA_WIDTH-1:0] addh,
  output logic [DATA_WIDTH-1:0] addl,
  output logic [DATA_WIDTH-1:0] sped,
  output logic [DATA_WIDTH-1:0] chan,
  output logic [DATA_WIDTH-1:0] option,
  output logic                  saved,
  output logic                  soft_rst_req,
  output logic                  aux_busy_n,
  output logic [1:0]            state_dbg
);

  localparam int TO_W = (CMD_TIMEOUT > 2) ? $clog2(CMD_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(CMD_TIMEOUT - 1);

  localparam logic [DATA_WIDTH-1:0] ADDH_RST   = DATA_WIDTH'(8'h00);
  localparam logic [DATA_WIDTH-1:0] ADDL_RST   = DATA_WIDTH'(8'h00);
  localparam logic [DATA_WIDTH-1:0] SPED_RST   = DATA_WIDTH'(8'h1A);
  localparam logic [DATA_WIDTH-1:0] CHAN_RST   = DATA_WIDTH'(8'h17);
  localparam logic [DATA_WIDTH-1:0] OPTION_RST = DATA_WIDTH'(8'h44);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    TRIPLE = 2'd2,
    REPLY  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [2:0]            byte_cnt_q, byte_cnt_d;
  logic [2:0]            match_cnt_q, match_cnt_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic [DATA_WIDTH-1:0] sh_addh_q, sh_addh_d, sh_addl_q, sh_addl_d;
  logic [DATA_WIDTH-1:0] sh_sped_q, sh_sped_d, sh_chan_q, sh_chan_d;
  logic [DATA_WIDTH-1:0] addh_q, addh_d, addl_q, addl_d, sped_q, sped_d;
  logic [DATA_WIDTH-1:0] chan_q, chan_d, option_q, option_d;
  logic                  saved_q, saved_d;
  logic                  soft_rst_q, soft_rst_d;
  logic [DATA_WIDTH-1:0] reply_first_q, reply_first_d;
  logic                  reply_ver_q, reply_ver_d;
  logic [2:0]            reply_idx_q, reply_idx_d;
  logic                  tx_gap_q, tx_gap_d;
  logic [DATA_WIDTH-1:0] reply_byte;
  logic [2:0]            reply_last;

  // Reply byte selection: echo/config replies share the register tail, the
  // version reply is a fixed 4-byte packet.
  always_comb begin
    reply_byte = '0;
    reply_last = reply_ver_q ? 3'd3 : 3'd5;
    case (reply_idx_q)
      3'd0:    reply_byte = reply_ver_q ? VERSION_PACKET_1 : reply_first_q;
      3'd1:    reply_byte = reply_ver_q ? VERSION_PACKET_2 : addh_q;
      3'd2:    reply_byte = reply_ver_q ? VERSION_PACKET_3 : addl_q;
      3'd3:    reply_byte = reply_ver_q ? VERSION_PACKET_4 : sped_q;
      3'd4:    reply_byte = chan_q;
      3'd5:    reply_byte = option_q;
      default: reply_byte = '0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    head_d        = head_q;
    byte_cnt_d    = byte_cnt_q;
    match_cnt_d   = match_cnt_q;
    to_cnt_d      = to_cnt_q;
    sh_addh_d     = sh_addh_q;
    sh_addl_d     = sh_addl_q;
    sh_sped_d     = sh_sped_q;
    sh_chan_d     = sh_chan_q;
    addh_d        = addh_q;
    addl_d        = addl_q;
    sped_d        = sped_q;
    chan_d        = chan_q;
    option_d      = option_q;
    saved_d       = saved_q;
    soft_rst_d    = 1'b0;
    reply_first_d = reply_first_q;
    reply_ver_d   = reply_ver_q;
    reply_idx_d   = reply_idx_q;
    tx_gap_d      = tx_gap_q;
    tx_use        = 1'b0;
    tx_data       = '0;

    case (state_q)
      IDLE: begin
        if (cmd_en && rx_flag) begin
          if (rx_data == HEAD_DETECT_1 || rx_data == HEAD_DETECT_2) begin
            state_d    = LOAD;
            head_d     = rx_data;
            byte_cnt_d = 3'd0;
            to_cnt_d   = '0;
          end else if (rx_data == RET_CONFIG_DETECT || rx_data == RET_VERSION_DETECT ||
                       rx_data == RESET_DETECT) begin
            state_d     = TRIPLE;
            head_d      = rx_data;
            match_cnt_d = 3'd1;
            to_cnt_d    = '0;
          end
        end
      end

      LOAD: begin
        if (!cmd_en) begin
          state_d    = IDLE;
          byte_cnt_d = 3'd0;
          to_cnt_d   = '0;
        end else if (rx_flag) begin
          to_cnt_d = '0;
          case (byte_cnt_q)
            3'd0:    sh_addh_d = rx_data;
            3'd1:    sh_addl_d = rx_data;
            3'd2:    sh_sped_d = rx_data;
            3'd3:    sh_chan_d = rx_data;
            default: ;
          endcase
          if (byte_cnt_q == 3'd4) begin
            // The OPTION byte goes straight to the output in the commit edge.
            addh_d        = sh_addh_q;
            addl_d        = sh_addl_q;
            sped_d        = sh_sped_q;
            chan_d        = sh_chan_q;
            option_d      = rx_data;
            saved_d       = (head_q == HEAD_DETECT_1);
            byte_cnt_d    = 3'd0;
            state_d       = REPLY;
            reply_first_d = head_q;
            reply_ver_d   = 1'b0;
            reply_idx_d   = 3'd0;
            tx_gap_d      = 1'b0;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end else if (to_cnt_q == TO_LAST) begin
          state_d    = IDLE;
          byte_cnt_d = 3'd0;
          to_cnt_d   = '0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      TRIPLE: begin
        if (!cmd_en) begin
          state_d     = IDLE;
          match_cnt_d = 3'd0;
          to_cnt_d    = '0;
        end else if (rx_flag) begin
          to_cnt_d = '0;
          if (rx_data != head_q) begin
            state_d     = IDLE;
            match_cnt_d = 3'd0;
          end else if (match_cnt_q == 3'd2) begin
            match_cnt_d = 3'd0;
            reply_idx_d = 3'd0;
            tx_gap_d    = 1'b0;
            if (head_q == RET_CONFIG_DETECT) begin
              state_d       = REPLY;
              reply_first_d = HEAD_DETECT_1;
              reply_ver_d   = 1'b0;
            end else if (head_q == RET_VERSION_DETECT) begin
              state_d     = REPLY;
              reply_ver_d = 1'b1;
            end else begin
              state_d    = IDLE;
              soft_rst_d = 1'b1;
            end
          end else begin
            match_cnt_d = match_cnt_q + 3'd1;
          end
        end else if (to_cnt_q == TO_LAST) begin
          state_d     = IDLE;
          match_cnt_d = 3'd0;
          to_cnt_d    = '0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      REPLY: begin
        // tx_ready is ignored for one cycle after each load so the UART can drop it.
        if (tx_gap_q) begin
          tx_gap_d = 1'b0;
        end else if (tx_ready) begin
          tx_use  = 1'b1;
          tx_data = reply_byte;
          if (reply_idx_q == reply_last) begin
            state_d     = IDLE;
            reply_idx_d = 3'd0;
            tx_gap_d    = 1'b0;
          end else begin
            reply_idx_d = reply_idx_q + 3'd1;
            tx_gap_d    = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge internal_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      head_q        <= '0;
      byte_cnt_q    <= 3'd0;
      match_cnt_q   <= 3'd0;
      to_cnt_q      <= '0;
      sh_addh_q     <= '0;
      sh_addl_q     <= '0;
      sh_sped_q     <= '0;
      sh_chan_q     <= '0;
      addh_q        <= ADDH_RST;
      addl_q        <= ADDL_RST;
      sped_q        <= SPED_RST;
      chan_q        <= CHAN_RST;
      option_q      <= OPTION_RST;
      saved_q       <= 1'b0;
      soft_rst_q    <= 1'b0;
      reply_first_q <= '0;
      reply_ver_q   <= 1'b0;
      reply_idx_q   <= 3'd0;
      tx_gap_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      byte_cnt_q    <= byte_cnt_d;
      match_cnt_q   <= match_cnt_d;
      to_cnt_q      <= to_cnt_d;
      sh_addh_q     <= sh_addh_d;
      sh_addl_q     <= sh_addl_d;
      sh_sped_q     <= sh_sped_d;
      sh_chan_q     <= sh_chan_d;
      addh_q        <= addh_d;
      addl_q        <= addl_d;
      sped_q        <= sped_d;
      chan_q        <= chan_d;
      option_q      <= option_d;
      saved_q       <= saved_d;
      soft_rst_q    <= soft_rst_d;
      reply_first_q <= reply_first_d;
      reply_ver_q   <= reply_ver_d;
      reply_idx_q   <= reply_idx_d;
      tx_gap_q      <= tx_gap_d;
    end
  end

  assign addh         = addh_q;
  assign addl         = addl_q;
  assign sped         = sped_q;
  assign chan         = chan_q;
  assign option       = option_q;
  assign saved        = saved_q;
  assign soft_rst_req = soft_rst_q;
  assign aux_busy_n   = (state_q == IDLE);
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_config_cmd_handler.sv
// Directed bench for config_cmd_handler: load/echo, queries, soft reset,
// timeout, aborts, tx_ready back-pressure and reset during a reply.
module tb_config_cmd_handler;

  localparam int T = 16;

  logic       clk;
  logic       rst_n;
  logic       cmd_en;
  logic       rx_flag;
  logic [7:0] rx_data;
  logic       tx_ready;
  logic       tx_use;
  logic [7:0] tx_data;
  logic [7:0] addh, addl, sped, chan, option;
  logic       saved;
  logic       soft_rst_req;
  logic       aux_busy_n;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int soft_cnt = 0;
  logic [7:0] tx_got[$];
  logic [7:0] exp_q[$];

  config_cmd_handler #(.CMD_TIMEOUT(T)) dut (
    .internal_clk(clk),
    .rst_n(rst_n),
    .cmd_en(cmd_en),
    .rx_flag(rx_flag),
    .rx_data(rx_data),
    .tx_ready(tx_ready),
    .tx_use(tx_use),
    .tx_data(tx_data),
    .addh(addh),
    .addl(addl),
    .sped(sped),
    .chan(chan),
    .option(option),
    .saved(saved),
    .soft_rst_req(soft_rst_req),
    .aux_busy_n(aux_busy_n),
    .state_dbg(state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor: inputs change 2ns after posedge, so negedge is a stable sample point.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_use) tx_got.push_back(tx_data);
      if (soft_rst_req) soft_cnt++;
    end
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_flag = 1'b1;
    rx_data = b;
    step(1);
    rx_flag = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic send3(input logic [7:0] b);
    send_byte(b);
    send_byte(b);
    send_byte(b);
  endtask

  task automatic wait_idle(input int budget, output logic timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (state_dbg == 2'd0) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(2);
    n_checks++; if (tx_use !== 1'b0) $display("FAIL reset_tx_use got=%b exp=0", tx_use); else n_pass++;
    n_checks++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data got=%h exp=00", tx_data); else n_pass++;
    n_checks++; if (soft_rst_req !== 1'b0) $display("FAIL reset_soft got=%b exp=0", soft_rst_req); else n_pass++;
    n_checks++; if (aux_busy_n !== 1'b1) $display("FAIL reset_aux got=%b exp=1", aux_busy_n); else n_pass++;
    n_checks++; if (saved !== 1'b0) $display("FAIL reset_saved got=%b exp=0", saved); else n_pass++;
    n_checks++; if ({addh, addl, sped, chan, option} !== 40'h00_00_1A_17_44)
      $display("FAIL reset_regs got=%h exp=00001a1744", {addh, addl, sped, chan, option}); else n_pass++;
    n_checks++; if (state_dbg !== 2'd0) $display("FAIL reset_state got=%0d exp=0", state_dbg); else n_pass++;
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_load_save();
    logic to;
    logic [7:0] g;
    tx_got.delete();
    exp_q = '{8'hC0, 8'h12, 8'h34, 8'h1D, 8'h06, 8'h44};
    send_byte(8'hC0); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'h1D); send_byte(8'h06); send_byte(8'h44);
    wait_idle(40, to);
    n_checks++; if (to !== 1'b0) $display("FAIL load_idle_timeout got=%b exp=0", to); else n_pass++;
    n_checks++; if ({addh, addl, sped, chan, option} !== 40'h12_34_1D_06_44)
      $display("FAIL load_regs got=%h exp=12341d0644", {addh, addl, sped, chan, option}); else n_pass++;
    n_checks++; if (saved !== 1'b1) $display("FAIL load_saved got=%b exp=1", saved); else n_pass++;
    n_checks++; if (tx_got.size() !== 6) $display("FAIL load_count got=%0d exp=6", tx_got.size()); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      g = (i < tx_got.size()) ? tx_got[i] : 8'hxx;
      n_checks++; if (g !== exp_q[i]) $display("FAIL load_byte%0d got=%h exp=%h", i, g, exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_version();
    logic to;
    logic [7:0] g;
    tx_got.delete();
    exp_q = '{8'hC3, 8'h32, 8'h27, 8'h02};
    send_byte(8'hC3);
    n_checks++; if (aux_busy_n !== 1'b0) $display("FAIL ver_busy_first got=%b exp=0", aux_busy_n); else n_pass++;
    send_byte(8'hC3);
    send_byte(8'hC3);
    n_checks++; if (aux_busy_n !== 1'b0) $display("FAIL ver_busy_reply got=%b exp=0", aux_busy_n); else n_pass++;
    wait_idle(40, to);
    n_checks++; if (to !== 1'b0) $display("FAIL ver_idle_timeout got=%b exp=0", to); else n_pass++;
    n_checks++; if (aux_busy_n !== 1'b1) $display("FAIL ver_busy_done got=%b exp=1", aux_busy_n); else n_pass++;
    n_checks++; if (tx_got.size() !== 4) $display("FAIL ver_count got=%0d exp=4", tx_got.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      g = (i < tx_got.size()) ? tx_got[i] : 8'hxx;
      n_checks++; if (g !== exp_q[i]) $display("FAIL ver_byte%0d got=%h exp=%h", i, g, exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_soft_reset();
    tx_got.delete();
    soft_cnt = 0;
    send3(8'hC4);
    step(5);
    n_checks++; if (soft_cnt !== 1) $display("FAIL soft_pulses got=%0d exp=1", soft_cnt); else n_pass++;
    n_checks++; if (tx_got.size() !== 0) $display("FAIL soft_tx got=%0d exp=0", tx_got.size()); else n_pass++;
    n_checks++; if (state_dbg !== 2'd0) $display("FAIL soft_state got=%0d exp=0", state_dbg); else n_pass++;
  endtask

  task automatic test_timeout();
    logic to;
    logic [7:0] g;
    apply_reset();
    tx_got.delete();
    exp_q = '{8'hC0, 8'h00, 8'h00, 8'h1A, 8'h17, 8'h44};
    send_byte(8'hC2); send_byte(8'h11); send_byte(8'h22);
    step(T - 1);
    n_checks++; if (state_dbg !== 2'd1) $display("FAIL to_before got=%0d exp=1", state_dbg); else n_pass++;
    step(1);
    n_checks++; if (state_dbg !== 2'd0) $display("FAIL to_expired got=%0d exp=0", state_dbg); else n_pass++;
    n_checks++; if ({addh, addl, sped, chan, option} !== 40'h00_00_1A_17_44)
      $display("FAIL to_no_commit got=%h exp=00001a1744", {addh, addl, sped, chan, option}); else n_pass++;
    send3(8'hC1);
    wait_idle(40, to);
    n_checks++; if (to !== 1'b0) $display("FAIL to_idle_timeout got=%b exp=0", to); else n_pass++;
    n_checks++; if (tx_got.size() !== 6) $display("FAIL to_count got=%0d exp=6", tx_got.size()); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      g = (i < tx_got.size()) ? tx_got[i] : 8'hxx;
      n_checks++; if (g !== exp_q[i]) $display("FAIL to_byte%0d got=%h exp=%h", i, g, exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_abort();
    tx_got.delete();
    send_byte(8'hC1); send_byte(8'hC1);
    cmd_en = 1'b0;
    step(1);
    n_checks++; if (state_dbg !== 2'd0) $display("FAIL abort_state got=%0d exp=0", state_dbg); else n_pass++;
    send_byte(8'hC1);
    step(3);
    n_checks++; if (state_dbg !== 2'd0) $display("FAIL abort_third got=%0d exp=0", state_dbg); else n_pass++;
    cmd_en = 1'b1;
    send_byte(8'hC1); send_byte(8'hC1); send_byte(8'hC3);
    n_checks++; if (state_dbg !== 2'd0) $display("FAIL mismatch_state got=%0d exp=0", state_dbg); else n_pass++;
    step(6);
    n_checks++; if (tx_got.size() !== 0) $display("FAIL abort_tx got=%0d exp=0", tx_got.size()); else n_pass++;
  endtask

  task automatic test_tx_ready_hold();
    logic to;
    logic [7:0] g;
    tx_got.delete();
    soft_cnt = 0;
    exp_q = '{8'hC0, 8'h00, 8'h00, 8'h1A, 8'h17, 8'h44};
    tx_ready = 1'b0;
    send3(8'hC1);
    send3(8'hC4);
    step(47);
    n_checks++; if (tx_got.size() !== 0) $display("FAIL hold_no_tx got=%0d exp=0", tx_got.size()); else n_pass++;
    n_checks++; if (state_dbg !== 2'd3) $display("FAIL hold_state got=%0d exp=3", state_dbg); else n_pass++;
    n_checks++; if (soft_cnt !== 0) $display("FAIL hold_rx_ignored got=%0d exp=0", soft_cnt); else n_pass++;
    tx_ready = 1'b1;
    wait_idle(40, to);
    n_checks++; if (to !== 1'b0) $display("FAIL hold_idle_timeout got=%b exp=0", to); else n_pass++;
    n_checks++; if (tx_got.size() !== 6) $display("FAIL hold_count got=%0d exp=6", tx_got.size()); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      g = (i < tx_got.size()) ? tx_got[i] : 8'hxx;
      n_checks++; if (g !== exp_q[i]) $display("FAIL hold_byte%0d got=%h exp=%h", i, g, exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic to;
    logic [7:0] g;
    tx_got.delete();
    exp_q = '{8'hC2, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE,
              8'hC0, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    send_byte(8'hC2); send_byte(8'hAA); send_byte(8'hBB);
    send_byte(8'hCC); send_byte(8'hDD); send_byte(8'hEE);
    wait_idle(40, to);
    n_checks++; if (saved !== 1'b0) $display("FAIL b2b_saved got=%b exp=0", saved); else n_pass++;
    send3(8'hC1);
    wait_idle(40, to);
    n_checks++; if (to !== 1'b0) $display("FAIL b2b_idle_timeout got=%b exp=0", to); else n_pass++;
    n_checks++; if (tx_got.size() !== 12) $display("FAIL b2b_count got=%0d exp=12", tx_got.size()); else n_pass++;
    for (int i = 0; i < 12; i++) begin
      g = (i < tx_got.size()) ? tx_got[i] : 8'hxx;
      n_checks++; if (g !== exp_q[i]) $display("FAIL b2b_byte%0d got=%h exp=%h", i, g, exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_reply();
    tx_got.delete();
    tx_ready = 1'b0;
    send3(8'hC1);
    rst_n = 1'b0;
    tx_ready = 1'b1;
    #1;
    n_checks++; if (tx_use !== 1'b0) $display("FAIL midrst_tx_use got=%b exp=0", tx_use); else n_pass++;
    n_checks++; if (state_dbg !== 2'd0) $display("FAIL midrst_state got=%0d exp=0", state_dbg); else n_pass++;
    step(3);
    n_checks++; if ({addh, option} !== 16'h00_44) $display("FAIL midrst_regs got=%h exp=0044", {addh, option}); else n_pass++;
    rst_n = 1'b1;
    step(10);
    n_checks++; if (tx_got.size() !== 0) $display("FAIL midrst_tx got=%0d exp=0", tx_got.size()); else n_pass++;
  endtask

  initial begin
    rst_n    = 1'b0;
    cmd_en   = 1'b1;
    rx_flag  = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;
    test_reset();
    test_load_save();
    test_version();
    test_soft_reset();
    test_timeout();
    test_abort();
    test_tx_ready_hold();
    test_back_to_back();
    test_reset_mid_reply();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
